// File: rtl/sram_march_bist_ctrl_if.sv
// ============================================================================
// sram_march_bist_ctrl_if : control and SRAM BIST-port bundle for the March C- controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface sram_march_bist_ctrl_if #(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_ADDR_WIDTH = 6,
    parameter int P_FCNT_WIDTH = 8
);
    logic                    A_BIST_START;
    logic                    A_BIST_BUSY;
    logic                    A_BIST_DONE;
    logic                    A_BIST_FAIL;
    logic [P_FCNT_WIDTH-1:0] A_BIST_FAIL_CNT;
    logic                    A_BIST_EN;
    logic                    A_BIST_MEN;
    logic                    A_BIST_WEN;
    logic                    A_BIST_REN;
    logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
    logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
    logic [P_DATA_WIDTH-1:0] A_BIST_BM;
    logic [P_DATA_WIDTH-1:0] A_DOUT;
    logic [P_ADDR_WIDTH-1:0] A_BIST_DIAG_ADDR;
    logic [2:0]              A_BIST_DIAG_ELEM;
    logic [P_DATA_WIDTH-1:0] A_BIST_DIAG_SYND;

    modport master (
        input  A_BIST_START, A_DOUT,
        output A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL, A_BIST_FAIL_CNT,
               A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
               A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
               A_BIST_DIAG_ADDR, A_BIST_DIAG_ELEM, A_BIST_DIAG_SYND
    );

    modport slave (
        output A_BIST_START, A_DOUT,
        input  A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL, A_BIST_FAIL_CNT,
               A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
               A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
               A_BIST_DIAG_ADDR, A_BIST_DIAG_ELEM, A_BIST_DIAG_SYND
    );
endinterface

`default_nettype wire

// File: rtl/sram_march_bist_ctrl.sv
// ============================================================================
// sram_march_bist_ctrl : March C- BIST controller; RM_BIST_DIAG_EN adds first-failure capture
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_march_bist_ctrl #(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_ADDR_WIDTH = 6,
    parameter int P_FCNT_WIDTH = 8
) (
    input  logic                   A_BIST_CLK,
    input  logic                   A_BIST_RESET_N,
    sram_march_bist_ctrl_if.master bist
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [P_ADDR_WIDTH-1:0] C_ADDR_MAX  = '1;
    localparam logic [2:0]              C_ELEM_LAST = 3'd5;

    state_t                  state_q;
    logic [2:0]              elem_q;
    logic [P_ADDR_WIDTH-1:0] acnt_q;
    logic                    phase_q;
    logic                    busy_q, done_q, fail_q;
    logic [P_FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                    en_q, men_q, wen_q, ren_q;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic [P_DATA_WIDTH-1:0] din_q, bm_q;
    logic                    op_exp_q, rd_pend_q, rd_exp_q;

    logic w_down, w_next_down, w_two_op, w_is_write, w_bg;
    logic w_last_op, w_addr_end, w_mismatch, w_start;

    // Element decode: E3/E4 descend, E1..E4 carry a read then a write per address.
    assign w_down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign w_next_down = (elem_q == 3'd2) || (elem_q == 3'd3);
    assign w_two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    assign w_is_write  = (elem_q == 3'd0) || phase_q;
    assign w_bg        = phase_q ? ((elem_q == 3'd1) || (elem_q == 3'd3))
                                 : ((elem_q == 3'd2) || (elem_q == 3'd4));
    assign w_last_op   = !w_two_op || phase_q;
    assign w_addr_end  = w_down ? (acnt_q == '0) : (acnt_q == C_ADDR_MAX);
    assign w_mismatch  = rd_pend_q && (bist.A_DOUT != {P_DATA_WIDTH{rd_exp_q}});
    assign w_start     = ((state_q == S_IDLE) || (state_q == S_DONE)) && bist.A_BIST_START;
    assign fcnt_d      = (fcnt_q == '1) ? fcnt_q : fcnt_q + P_FCNT_WIDTH'(1);

    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RESET_N) begin
        if (!A_BIST_RESET_N) begin
            state_q   <= S_IDLE;
            elem_q    <= '0;
            acnt_q    <= '0;
            phase_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            fcnt_q    <= '0;
            en_q      <= 1'b0;
            men_q     <= 1'b0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            bm_q      <= '0;
            op_exp_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_exp_q  <= 1'b0;
        end else begin
            // Read data returns one cycle after issue; compare one edge later.
            rd_pend_q <= ren_q;
            rd_exp_q  <= op_exp_q;
            if (w_mismatch) begin
                fail_q <= 1'b1;
                fcnt_q <= fcnt_d;
            end

            case (state_q)
                S_RUN: begin
                    busy_q   <= 1'b1;
                    en_q     <= 1'b1;
                    men_q    <= 1'b1;
                    wen_q    <= w_is_write;
                    ren_q    <= !w_is_write;
                    addr_q   <= acnt_q;
                    din_q    <= {P_DATA_WIDTH{w_bg}};
                    bm_q     <= '1;
                    op_exp_q <= w_bg;
                    if (w_last_op) begin
                        phase_q <= 1'b0;
                        if (w_addr_end) begin
                            elem_q <= elem_q + 3'd1;
                            acnt_q <= w_next_down ? C_ADDR_MAX : '0;
                            if (elem_q == C_ELEM_LAST) begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            acnt_q <= w_down ? acnt_q - 1'b1 : acnt_q + 1'b1;
                        end
                    end else begin
                        phase_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    men_q   <= 1'b0;
                    wen_q   <= 1'b0;
                    ren_q   <= 1'b0;
                    din_q   <= '0;
                    bm_q    <= '0;
                    state_q <= S_DONE;
                end
                default: begin
                    busy_q <= 1'b0;
                    en_q   <= 1'b0;
                    men_q  <= 1'b0;
                    wen_q  <= 1'b0;
                    ren_q  <= 1'b0;
                    addr_q <= '0;
                    din_q  <= '0;
                    bm_q   <= '0;
                    if (state_q == S_DONE) begin
                        done_q <= 1'b1;
                    end
                    if (w_start) begin
                        state_q <= S_RUN;
                        done_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        fcnt_q  <= '0;
                        elem_q  <= '0;
                        acnt_q  <= '0;
                        phase_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bist.A_BIST_BUSY     = busy_q;
    assign bist.A_BIST_DONE     = done_q;
    assign bist.A_BIST_FAIL     = fail_q;
    assign bist.A_BIST_FAIL_CNT = fcnt_q;
    assign bist.A_BIST_EN       = en_q;
    assign bist.A_BIST_MEN      = men_q;
    assign bist.A_BIST_WEN      = wen_q;
    assign bist.A_BIST_REN      = ren_q;
    assign bist.A_BIST_ADDR     = addr_q;
    assign bist.A_BIST_DIN      = din_q;
    assign bist.A_BIST_BM       = bm_q;

`ifdef RM_BIST_DIAG_EN
    logic [2:0]              op_elem_q, rd_elem_q, dg_elem_q;
    logic [P_ADDR_WIDTH-1:0] rd_addr_q, dg_addr_q;
    logic [P_DATA_WIDTH-1:0] dg_synd_q;

    // Address/element travel with the read so the capture matches the failing op.
    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RESET_N) begin
        if (!A_BIST_RESET_N) begin
            op_elem_q <= '0;
            rd_elem_q <= '0;
            rd_addr_q <= '0;
            dg_elem_q <= '0;
            dg_addr_q <= '0;
            dg_synd_q <= '0;
        end else begin
            op_elem_q <= elem_q;
            rd_elem_q <= op_elem_q;
            rd_addr_q <= addr_q;
            if (w_start) begin
                dg_elem_q <= '0;
                dg_addr_q <= '0;
                dg_synd_q <= '0;
            end else if (w_mismatch && !fail_q) begin
                dg_elem_q <= rd_elem_q;
                dg_addr_q <= rd_addr_q;
                dg_synd_q <= bist.A_DOUT ^ {P_DATA_WIDTH{rd_exp_q}};
            end
        end
    end

    assign bist.A_BIST_DIAG_ADDR = dg_addr_q;
    assign bist.A_BIST_DIAG_ELEM = dg_elem_q;
    assign bist.A_BIST_DIAG_SYND = dg_synd_q;
`else
    assign bist.A_BIST_DIAG_ADDR = '0;
    assign bist.A_BIST_DIAG_ELEM = '0;
    assign bist.A_BIST_DIAG_SYND = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_march_bist_ctrl.sv
// ============================================================================
// tb_sram_march_bist_ctrl : randomized fault-injection bench with a March C- reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_march_bist_ctrl;
    localparam int DW   = 64;
    localparam int AW   = 6;
    localparam int N    = 64;
    localparam int NOPS = 640;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_march_bist_ctrl_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_FCNT_WIDTH(8)) bif ();
    sram_march_bist_ctrl_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_FCNT_WIDTH(4)) bif4 ();

    sram_march_bist_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_FCNT_WIDTH(8)) u_dut (
        .A_BIST_CLK     (clk),
        .A_BIST_RESET_N (rst_n),
        .bist           (bif)
    );

    sram_march_bist_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_FCNT_WIDTH(4)) u_dut4 (
        .A_BIST_CLK     (clk),
        .A_BIST_RESET_N (rst_n),
        .bist           (bif4)
    );

    assign bif4.A_DOUT = '0;

    // March C- as written: per element count, direction, and (write?, value) per op.
    int el_n  [6]    = '{1, 2, 2, 2, 2, 1};
    bit el_dn [6]    = '{0, 0, 0, 1, 1, 0};
    bit el_w  [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    bit el_v  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

    bit ref_we   [NOPS];
    bit ref_val  [NOPS];
    int ref_addr [NOPS];
    int ref_elem [NOPS];

    int n_checks = 0;
    int n_errors = 0;

    bit fault_en = 0;
    bit force0   = 0;
    int fa = 0;
    int fb = 0;
    bit fv = 0;

    logic [DW-1:0] mem [N];

    function automatic logic [DW-1:0] read_fault(input logic [DW-1:0] d, input int a);
        logic [DW-1:0] r;
        r = d;
        if (force0) r = '0;
        else if (fault_en && a == fa) r[fb] = fv;
        return r;
    endfunction

    // Behavioural SRAM: 1-cycle read latency, bit-masked writes.
    always @(posedge clk) begin
        if (bif.A_BIST_MEN && bif.A_BIST_WEN)
            mem[bif.A_BIST_ADDR] <= (mem[bif.A_BIST_ADDR] & ~bif.A_BIST_BM) | (bif.A_BIST_DIN & bif.A_BIST_BM);
        if (bif.A_BIST_MEN && bif.A_BIST_REN)
            bif.A_DOUT <= read_fault(mem[bif.A_BIST_ADDR], int'(bif.A_BIST_ADDR));
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_ref();
        int k = 0;
        for (int e = 0; e < 6; e++)
            for (int j = 0; j < N; j++)
                for (int p = 0; p < el_n[e]; p++) begin
                    ref_elem[k] = e;
                    ref_addr[k] = el_dn[e] ? (N - 1 - j) : j;
                    ref_we[k]   = el_w[e][p];
                    ref_val[k]  = el_v[e][p];
                    k++;
                end
    endtask

    function automatic logic outs_any(input int unused);
        return |{bif.A_BIST_BUSY, bif.A_BIST_DONE, bif.A_BIST_FAIL, bif.A_BIST_FAIL_CNT,
                 bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN,
                 bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM,
                 bif.A_BIST_DIAG_ADDR, bif.A_BIST_DIAG_ELEM, bif.A_BIST_DIAG_SYND,
                 bif4.A_BIST_BUSY, bif4.A_BIST_FAIL_CNT, bif4.A_BIST_EN} | (unused != 0);
    endfunction

    // Starts a test from a point #1 after a rising edge; returns #1 after the edge ending it.
    task automatic run_test(input int mid_start_at, input int rst_at, input bit also4);
        int cnt = 0, cnt4 = 0, nr = 0, nw = 0;
        int f_addr = 0, f_elem = 0;
        logic [DW-1:0] f_synd = '0, bg, ob;
        logic [136:0] op_obs, op_exp;

        for (int i = 0; i < NOPS; i++) begin
            if (!ref_we[i]) begin
                bg = {DW{ref_val[i]}};
                ob = read_fault(bg, ref_addr[i]);
                if (ref_val[i]) cnt4++;
                if (ob != bg) begin
                    if (cnt == 0) begin
                        f_addr = ref_addr[i];
                        f_elem = ref_elem[i];
                        f_synd = ob ^ bg;
                    end
                    cnt++;
                end
            end
        end

        bif.A_BIST_START = 1'b1;
        if (also4) bif4.A_BIST_START = 1'b1;
        @(posedge clk); #1;
        bif.A_BIST_START  = 1'b0;
        bif4.A_BIST_START = 1'b0;
        check("done_clr_e0", 256'(bif.A_BIST_DONE), 256'(0));
        check("busy_e0", 256'(bif.A_BIST_BUSY), 256'(0));

        for (int i = 0; i < NOPS; i++) begin
            @(posedge clk); #1;
            bif.A_BIST_START = (i == mid_start_at);
            if (i == rst_at) begin
                bif.A_BIST_START = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rst_mid_outs", 256'(outs_any(0)), 256'(0));
                @(posedge clk); #1;
                check("rst_hold_outs", 256'(outs_any(0)), 256'(0));
                rst_n = 1'b1;
                @(posedge clk); #1;
                check("rst_idle_outs", 256'(outs_any(0)), 256'(0));
                return;
            end
            op_obs = {bif.A_BIST_EN, bif.A_BIST_BUSY, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN,
                      bif.A_BIST_ADDR, (bif.A_BIST_WEN ? bif.A_BIST_DIN : {DW{1'b0}}), bif.A_BIST_BM}[136:0];
            op_exp = {1'b1, 1'b1, 1'b1, ref_we[i], !ref_we[i], AW'(ref_addr[i]),
                      (ref_we[i] ? {DW{ref_val[i]}} : {DW{1'b0}}), {DW{1'b1}}}[136:0];
            check($sformatf("op%0d", i), 256'(op_obs), 256'(op_exp));
            if (bif.A_BIST_MEN && bif.A_BIST_REN) nr++;
            if (bif.A_BIST_MEN && bif.A_BIST_WEN) nw++;
        end
        bif.A_BIST_START = 1'b0;

        @(posedge clk); #1;
        check("drain", 256'({bif.A_BIST_BUSY, bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN,
                             bif.A_BIST_REN, bif.A_BIST_DONE}), 256'(6'b110000));
        @(posedge clk); #1;
        check("done_state", 256'({bif.A_BIST_DONE, bif.A_BIST_BUSY, bif.A_BIST_EN, bif.A_BIST_MEN}),
              256'(4'b1000));
        check("bm_done", 256'(bif.A_BIST_BM), 256'(0));
        check("fail", 256'(bif.A_BIST_FAIL), 256'(cnt != 0));
        check("fail_cnt", 256'(bif.A_BIST_FAIL_CNT), 256'((cnt > 255) ? 255 : cnt));
        check("n_reads", 256'(nr), 256'(5 * N));
        check("n_writes", 256'(nw), 256'(5 * N));
`ifdef RM_BIST_DIAG_EN
        check("diag_addr", 256'(bif.A_BIST_DIAG_ADDR), 256'(f_addr));
        check("diag_elem", 256'(bif.A_BIST_DIAG_ELEM), 256'(f_elem));
        check("diag_synd", 256'(bif.A_BIST_DIAG_SYND), 256'(f_synd));
`else
        check("diag_tied", 256'({bif.A_BIST_DIAG_ADDR, bif.A_BIST_DIAG_ELEM, bif.A_BIST_DIAG_SYND}), 256'(0));
`endif
        if (also4) begin
            check("fcnt4_sat", 256'(bif4.A_BIST_FAIL_CNT), 256'((cnt4 > 15) ? 15 : cnt4));
            check("fail4", 256'(bif4.A_BIST_FAIL), 256'(cnt4 != 0));
        end
    endtask

    initial begin
        bif.A_BIST_START  = 1'b0;
        bif4.A_BIST_START = 1'b0;
        build_ref();

        #2;
        check("reset_outs", 256'(outs_any(0)), 256'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_outs", 256'(outs_any(0)), 256'(0));

        run_test(100, -1, 0);            // fault-free, START ignored mid-run

        fault_en = 1; fa = 'h2A; fb = 5; fv = 0;
        run_test(-1, -1, 0);             // stuck-at-0 bit 5 @ 0x2A

        fault_en = 0;
        run_test(-1, -1, 0);             // restart from DONE clears flags

        for (int r = 0; r < 3; r++) begin
            fault_en = 1;
            fa = int'($urandom_range(0, N - 1));
            fb = int'($urandom_range(0, DW - 1));
            fv = 1'($urandom_range(0, 1));
            run_test(int'($urandom_range(0, NOPS - 1)), -1, 0);
        end

        fault_en = 0; force0 = 1;
        run_test(-1, -1, 1);             // all-zero read data, 8- and 4-bit counters

        force0 = 0;
        run_test(-1, 300, 0);            // reset mid-test
        run_test(-1, -1, 0);             // full clean run after reset

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
